// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver and its word FIFO.
//   rx_state_e : receiver FSM states
//   STOP_BIT   : line level that marks a valid stop bit
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic STOP_BIT = 1'b1;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1-style receiver: synchronizes the serial line, samples each bit mid-period and
// emits one word per good frame.
//   clk, rst        : clock, asynchronous active-high reset
//   i_data          : asynchronous serial line, idle high
//   o_word          : received word (valid while o_valid is high)
//   o_valid         : one-cycle pulse per good frame
//   o_frame_err     : one-cycle pulse when the stop bit is low
module uart_rx
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned LSB_FIRST    = 1,
  parameter int unsigned NUM_BITS     = 8,
  parameter int unsigned CLKS_PER_BIT = 3200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_data,
  output logic [NUM_BITS-1:0] o_word,
  output logic                o_valid,
  output logic                o_frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

  logic [1:0]          r_sync;
  rx_state_e           r_state, w_state_d;
  logic [CW-1:0]       r_clk_cnt, w_clk_cnt_d;
  logic [BW-1:0]       r_bit_cnt, w_bit_cnt_d;
  logic [NUM_BITS-1:0] r_shift, w_shift_d;
  logic                r_valid, w_valid_d;
  logic                r_ferr, w_ferr_d;
  logic                r_wait, w_wait_d;  // bad stop seen, waiting for line to return high
  logic                w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_wait    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_data};
      r_state   <= w_state_d;
      r_clk_cnt <= w_clk_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_valid   <= w_valid_d;
      r_ferr    <= w_ferr_d;
      r_wait    <= w_wait_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_clk_cnt_d = r_clk_cnt + 1'b1;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_valid_d   = 1'b0;
    w_ferr_d    = 1'b0;
    w_wait_d    = r_wait;
    unique case (r_state)
      IDLE: begin
        w_clk_cnt_d = '0;
        if (!w_rx) begin
          w_state_d   = START;
          w_bit_cnt_d = '0;
        end
      end
      START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_d = '0;
          w_state_d   = w_rx ? IDLE : DATA;  // high at mid start bit is a glitch
        end
      end
      DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_d = '0;
          if (LSB_FIRST != 0) w_shift_d = {w_rx, r_shift[NUM_BITS-1:1]};
          else                w_shift_d = {r_shift[NUM_BITS-2:0], w_rx};
          if (r_bit_cnt == LAST_BIT) w_state_d = STOP;
          else                       w_bit_cnt_d = r_bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_wait) begin
          w_clk_cnt_d = '0;
          if (w_rx) begin
            w_wait_d  = 1'b0;
            w_state_d = IDLE;
          end
        end else if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_d = '0;
          if (w_rx == STOP_BIT) begin
            w_valid_d = 1'b1;
            w_state_d = IDLE;
          end else begin
            w_ferr_d = 1'b1;
            w_wait_d = 1'b1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign o_word      = r_shift;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver followed by a show-ahead word FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   i_data          : asynchronous serial line, idle high
//   word_out_valid  : pop strobe, one word per cycle high
//   word_out        : FIFO head word, 0 when empty
//   word_rdy        : FIFO not empty
//   fifo_count      : number of stored words
//   overflow        : sticky, a word was dropped on a full FIFO
//   frame_err       : one-cycle pulse on a bad stop bit
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned LSB_FIRST    = 1,
  parameter int unsigned NUM_BITS     = 8,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned CLKS_PER_BIT = 3200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_data,
  input  logic                          word_out_valid,
  output logic [NUM_BITS-1:0]           word_out,
  output logic                          word_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

  logic [NUM_BITS-1:0] w_rx_word;
  logic                w_rx_valid;

  uart_rx #(
    .LSB_FIRST   (LSB_FIRST),
    .NUM_BITS    (NUM_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .o_word     (w_rx_word),
    .o_valid    (w_rx_valid),
    .o_frame_err(frame_err)
  );

  logic [NUM_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0]     r_count;
  logic                r_overflow;
  logic                w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = word_out_valid && !w_empty;
  // A full FIFO still accepts a word when the same cycle frees a slot.
  assign w_push  = w_rx_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rx_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_rx_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign word_out   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign word_rdy   = !w_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_data = 1'b1;
  logic       pop = 1'b0;
  logic       pop_m = 1'b0;
  logic [7:0] word_out, word_out_m;
  logic       word_rdy, word_rdy_m;
  logic [6:0] fifo_count, fifo_count_m;
  logic       overflow, overflow_m;
  logic       frame_err, frame_err_m;

  int n_checks = 0;
  int n_pass   = 0;
  int ferr_pulses = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .LSB_FIRST(1), .NUM_BITS(8), .FIFO_DEPTH(64), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .word_out_valid(pop),
    .word_out(word_out), .word_rdy(word_rdy), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err)
  );

  uart_rx_fifo #(
    .LSB_FIRST(0), .NUM_BITS(8), .FIFO_DEPTH(64), .CLKS_PER_BIT(CPB)
  ) dut_msb (
    .clk(clk), .rst(rst), .i_data(i_data), .word_out_valid(pop_m),
    .word_out(word_out_m), .word_rdy(word_rdy_m), .fifo_count(fifo_count_m),
    .overflow(overflow_m), .frame_err(frame_err_m)
  );

  always @(negedge clk) if (frame_err) ferr_pulses++;

  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_data = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_data = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_data = stop;
    repeat (CPB) @(negedge clk);
    i_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({word_rdy, word_out, fifo_count, overflow, frame_err} !== 18'd0)
      $display("FAIL reset_outputs rdy=%b out=%h cnt=%0d ovf=%b ferr=%b want all 0",
               word_rdy, word_out, fifo_count, overflow, frame_err);
    else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    send_byte(8'h90, 1'b1);
    n_checks++;
    if (word_rdy !== 1'b1 || word_out !== 8'h90 || fifo_count !== 7'd1)
      $display("FAIL single_rx rdy=%b out=%h cnt=%0d want 1 90 1", word_rdy, word_out, fifo_count);
    else n_pass++;
    pop_one();
    n_checks++;
    if (word_rdy !== 1'b0 || word_out !== 8'h00 || fifo_count !== 7'd0)
      $display("FAIL single_pop rdy=%b out=%h cnt=%0d want 0 00 0", word_rdy, word_out, fifo_count);
    else n_pass++;
    pop_one();  // pop while empty is ignored
    n_checks++;
    if (fifo_count !== 7'd0 || word_rdy !== 1'b0)
      $display("FAIL empty_pop cnt=%0d rdy=%b want 0 0", fifo_count, word_rdy);
    else n_pass++;
  endtask

  task automatic test_order();
    logic [7:0] exp_w [3];
    exp_w[0] = 8'h90; exp_w[1] = 8'h3C; exp_w[2] = 8'h7F;
    for (int i = 0; i < 3; i++) send_byte(exp_w[i], 1'b1);
    n_checks++;
    if (fifo_count !== 7'd3)
      $display("FAIL order_count got %0d want 3", fifo_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (word_out !== exp_w[i] || fifo_count !== 7'(3 - i))
        $display("FAIL order_word%0d got %h cnt %0d want %h cnt %0d",
                 i, word_out, fifo_count, exp_w[i], 3 - i);
      else n_pass++;
      pop_one();
    end
    n_checks++;
    if (fifo_count !== 7'd0 || word_rdy !== 1'b0)
      $display("FAIL order_empty cnt=%0d rdy=%b want 0 0", fifo_count, word_rdy);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int bad = 0;
    for (int i = 0; i <= 64; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 63) begin
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow);
        else n_pass++;
      end
    end
    n_checks++;
    if (fifo_count !== 7'd64 || overflow !== 1'b1 || word_out !== 8'h00)
      $display("FAIL ovf_full cnt=%0d ovf=%b out=%h want 64 1 00", fifo_count, overflow, word_out);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      if (word_out !== 8'(i)) begin
        bad++;
        $display("FAIL ovf_drain%0d got %h want %h", i, word_out, 8'(i));
      end
      pop_one();
    end
    n_checks++;
    if (bad != 0) $display("FAIL ovf_drain_words got %0d bad want 0", bad);
    else n_pass++;
    n_checks++;
    if (word_rdy !== 1'b0 || fifo_count !== 7'd0 || overflow !== 1'b1)
      $display("FAIL ovf_after rdy=%b cnt=%0d ovf=%b want 0 0 1", word_rdy, fifo_count, overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hC3;
    send_byte(8'h11, 1'b1);  // leave a word stored so reset has something to clear
    i_data = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      i_data = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_data = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({word_rdy, word_out, fifo_count, overflow, frame_err} !== 18'd0)
      $display("FAIL midrst_outputs rdy=%b out=%h cnt=%0d ovf=%b ferr=%b want all 0",
               word_rdy, word_out, fifo_count, overflow, frame_err);
    else n_pass++;
    i_data = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (CPB * 6) @(negedge clk);
    n_checks++;
    if (fifo_count !== 7'd0) $display("FAIL midrst_nopush cnt=%0d want 0", fifo_count);
    else n_pass++;
    send_byte(8'hA5, 1'b1);
    n_checks++;
    if (word_out !== 8'hA5 || fifo_count !== 7'd1)
      $display("FAIL midrst_next out=%h cnt=%0d want a5 1", word_out, fifo_count);
    else n_pass++;
    pop_one();
  endtask

  task automatic test_glitch_bad_stop();
    ferr_pulses = 0;
    i_data = 1'b0;
    repeat (6) @(negedge clk);
    i_data = 1'b1;
    repeat (CPB * 3) @(negedge clk);
    n_checks++;
    if (fifo_count !== 7'd0 || ferr_pulses != 0)
      $display("FAIL glitch cnt=%0d ferr_pulses=%0d want 0 0", fifo_count, ferr_pulses);
    else n_pass++;
    send_byte(8'h55, 1'b0);
    repeat (CPB) @(negedge clk);
    n_checks++;
    if (ferr_pulses != 1 || fifo_count !== 7'd0)
      $display("FAIL bad_stop ferr_pulses=%0d cnt=%0d want 1 0", ferr_pulses, fifo_count);
    else n_pass++;
    send_byte(8'h3C, 1'b1);
    n_checks++;
    if (word_out !== 8'h3C || fifo_count !== 7'd1)
      $display("FAIL after_bad_stop out=%h cnt=%0d want 3c 1", word_out, fifo_count);
    else n_pass++;
    pop_one();
  endtask

  task automatic test_msb_first();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h90, 1'b1);
    n_checks++;
    if (word_out_m !== 8'h09 || word_rdy_m !== 1'b1)
      $display("FAIL msb_first out=%h rdy=%b want 09 1", word_out_m, word_rdy_m);
    else n_pass++;
    n_checks++;
    if (word_out !== 8'h90) $display("FAIL lsb_same_line out=%h want 90", word_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_reset_mid_frame();
    test_glitch_bad_stop();
    test_msb_first();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
